spi_flash_model: RTL and testbench
==================================

// Module: spi_flash_model
// PURPOSE
//  Behavioural SPI NOR flash slave for simulation: decodes 03h READ, 0Bh FAST READ, 9Fh JEDEC ID, 05h READ STATUS.
//  Sits on one chip-select of the SoC SPI master. Fetches 64-bit words through an external synchronous read port
//  (bridged to DPI flash_read by spi_flash_rd_port); streams unbounded reads with prefetch and address wrap.
//  Unsupported opcodes raise a sticky error flag; the model does not stop simulation.
// PARAMETERS
//  CS_NUM        2            width of cs bus
//  CS_IDX        0            cs bit owned by this model (active-low select)
//  ADDR_BITS     24           flash address width; read address wraps modulo 2**ADDR_BITS
//  DUMMY_CYCLES  8            dummy clocks between address and data for 0Bh
//  JEDEC_ID      24'hEF4017   manufacturer/device id returned by 9Fh
// PORTS
//  clk        in   1        SPI clock (SCK); mosi sampled, miso updated on posedge
//  rst_n      in   1        async active-low reset
//  cs         in   CS_NUM   chip selects, active low; cs[CS_IDX]=1 async-resets transaction state
//  mosi       in   1        serial in, MSB first
//  miso       out  1        serial out, MSB first
//  mem_ren    out  1        word read request (comb), one cycle per fetch
//  mem_addr   out  32       byte address of word, bits[2:0]=0, upper bits above ADDR_BITS zero
//  mem_rdata  in   64       word data, valid from posedge after the mem_ren cycle; byte k = mem_rdata[8k+7:8k]
//  err        out  1        sticky: unsupported opcode seen
//  err_cmd    out  8        opcode that set err
// BEHAVIOUR
//  Reset (rst_n=0): state=CMD, counters 0, miso=0, mem_ren=0, err=0, err_cmd=0. cs deselect clears all but err/err_cmd.
//  States: CMD -> ADDR(03h,0Bh) | ID(9Fh) | STAT(05h) | ERR(other); ADDR -> DUMMY(0Bh) | DATA(03h); DUMMY -> DATA.
//  CMD: 8 posedges shift opcode; decision made on 8th. ERR: set err, capture err_cmd, miso=0 until deselect.
//  ADDR: bit counter c=0..23, one address bit per posedge. mem_ren=1 during c=21 with word addr addr[23:3]
//    (first 21 bits); rdata loaded into word register at posedge c=23; bit ptr := {addr[2:0],3'b0}.
//  03h: first data bit on miso immediately after 32nd posedge (no gap). 0Bh: miso=0 for DUMMY_CYCLES, then data.
//  DATA: miso = word[8*ptr[5:3] + 7 - ptr[2:0]]; ptr increments per posedge, wraps 63->0.
//    Prefetch: mem_ren=1 while ptr==62, mem_addr = next word; word register loaded at posedge where ptr==63.
//    Next word = (cur+8) mod 2**ADDR_BITS (0xFFFFF8 -> 0x000000 for 24 bits). Unbounded until deselect.
//  ID: shifts JEDEC_ID MSB first, repeats every 24 bits. STAT: returns 8'h00 repeatedly (never busy).
//  Deselect mid-anything: async abort, miso=0, next select starts at CMD; an outstanding fetch is dropped.
//  rst_n low mid-transfer: miso=0 same instant; err cleared only by rst_n.
//  mem_ren never asserted outside ADDR c=21 and DATA ptr==62; at most one request in flight.
// STRUCTURE
//  Package spi_flash_pkg: state_t enum {CMD,ADDR,DUMMY,DATA,ID,STAT,ERR}; opcodes OP_READ=8'h03,
//    OP_FAST=8'h0B, OP_RDID=8'h9F, OP_RDSR=8'h05.
//  This block has no sub-modules; spi_flash_rd_port (DPI flash_read bridge, 1-cycle latency) sits beside it
//    in the top-level wrapper.
// TESTING
//  mem[0x0]=64'h0807060504030201, mem[0x8]=64'h100F0E0D0C0B0A09
//  1 03h addr 0x000005, 40 clocks -> miso bytes 06 07 08 09 0A; mem_ren addr 0x0 (c=21) then 0x8 at ptr==62.
//  2 0Bh addr 0x000000, DUMMY_CYCLES=8 -> 8 zero bits then 01 02 03; no extra fetch during dummy.
//  3 03h addr 0xFFFFFE, mem[0xFFFFF8]=64'hBBAA<<48 -> bytes AA BB then fetch mem_addr 0x0, byte 01.
//  4 9Fh, 48 clocks -> EF 40 17 EF 40 17; 05h -> 00 00; mem_ren stays 0 for both.
//  5 opcode 02h -> err=1, err_cmd=02, miso=0; deselect/reselect with 03h works, err stays 1 until rst_n.
//  6 deselect after 10 addr bits, then full 03h 0x8 -> 09 0A; rst_n low in DATA -> miso=0, err=0 at once.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared state encoding and opcode values for the behavioural SPI NOR flash slave.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DUMMY,
    DATA,
    ID,
    STAT,
    ERR
  } state_t;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PTR_W  = 6;
  localparam int unsigned WORD_W = 64;

endpackage

// File: rtl/spi_flash_model.sv
// SPI NOR flash slave: decodes READ/FAST READ/JEDEC ID/READ STATUS and streams 64-bit
// words fetched through a synchronous read port, with single-word prefetch and address wrap.
module spi_flash_model
  import spi_flash_pkg::*;
#(
  parameter int unsigned CS_NUM       = 2,
  parameter int unsigned CS_IDX       = 0,
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4017
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CS_NUM-1:0] cs,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_ren,
  output logic [31:0]       mem_addr,
  input  logic [63:0]       mem_rdata,
  output logic              err,
  output logic [7:0]        err_cmd
);

  localparam int unsigned WA_W = ADDR_BITS - 3;

  // Transaction state is cleared by either reset or deselect; err survives deselect.
  logic tx_rst_n;
  assign tx_rst_n = rst_n & ~cs[CS_IDX];

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [ADDR_BITS-2:0] sh, sh_nx;
  logic                 fast, fast_nx;
  logic [PTR_W-1:0]     ptr, ptr_nx;
  logic [WORD_W-1:0]    word, word_nx;
  logic [WA_W-1:0]      waddr, waddr_nx;
  logic                 err_set_c;
  logic [7:0]           opc_c;
  logic [ADDR_BITS-1:0] addr_c;

  assign opc_c  = {sh[6:0], mosi};
  assign addr_c = {sh, mosi};

  always_ff @(posedge clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state <= CMD;
      cnt   <= '0;
      sh    <= '0;
      fast  <= 1'b0;
      ptr   <= '0;
      word  <= '0;
      waddr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh    <= sh_nx;
      fast  <= fast_nx;
      ptr   <= ptr_nx;
      word  <= word_nx;
      waddr <= waddr_nx;
    end
  end

  // Only the first unsupported opcode is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cmd <= '0;
    end else if (err_set_c && !err) begin
      err     <= 1'b1;
      err_cmd <= opc_c;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sh_nx     = sh;
    fast_nx   = fast;
    ptr_nx    = ptr;
    word_nx   = word;
    waddr_nx  = waddr;
    err_set_c = 1'b0;
    unique case (state)
      CMD: begin
        sh_nx  = {sh[ADDR_BITS-3:0], mosi};
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_W'(7)) begin
          cnt_nx = '0;
          case (opc_c)
            OP_READ: begin state_nx = ADDR; fast_nx = 1'b0; end
            OP_FAST: begin state_nx = ADDR; fast_nx = 1'b1; end
            OP_RDID: state_nx = ID;
            OP_RDSR: state_nx = STAT;
            default: begin
              state_nx  = ERR;
              err_set_c = 1'b1;
            end
          endcase
        end
      end
      ADDR: begin
        sh_nx  = {sh[ADDR_BITS-3:0], mosi};
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ADDR_BITS - 1)) begin
          cnt_nx   = '0;
          word_nx  = mem_rdata;
          ptr_nx   = {addr_c[2:0], 3'b000};
          waddr_nx = addr_c[ADDR_BITS-1:3];
          state_nx = (fast && (DUMMY_CYCLES != 0)) ? DUMMY : DATA;
        end
      end
      DUMMY: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
          cnt_nx   = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        ptr_nx = ptr + PTR_W'(1);
        if (ptr == PTR_W'(63)) begin
          word_nx  = mem_rdata;
          waddr_nx = waddr + WA_W'(1);
        end
      end
      ID: cnt_nx = (cnt == CNT_W'(23)) ? '0 : cnt + CNT_W'(1);
      default: ;
    endcase
  end

  // Serial output and read requests are decoded straight from state so both drop at reset/deselect.
  always_comb begin
    miso     = 1'b0;
    mem_ren  = 1'b0;
    mem_addr = '0;
    unique case (state)
      ADDR: begin
        if (cnt == CNT_W'(ADDR_BITS - 3)) begin
          mem_ren  = 1'b1;
          mem_addr = 32'({sh[ADDR_BITS-4:0], 3'b000});
        end
      end
      DATA: begin
        miso = word[{ptr[5:3], ~ptr[2:0]}];
        if (ptr == PTR_W'(62)) begin
          mem_ren  = 1'b1;
          mem_addr = 32'({waddr + WA_W'(1), 3'b000});
        end
      end
      ID: miso = JEDEC_ID[5'(5'd23 - cnt[4:0])];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_model.sv
// Self-checking bench for spi_flash_model: directed vector table, random transactions
// against a byte-level reference model, and hand-written abort/reset sequences.
module tb_spi_flash_model;
  import spi_flash_pkg::*;

  localparam int unsigned DUMMY = 8;
  localparam logic [23:0] JID   = 24'hEF4017;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cs = 2'b11;
  logic        mosi = 1'b0;
  logic        miso;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic        err;
  logic [7:0]  err_cmd;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] mem [logic [31:0]];
  logic [31:0] fetchq[$];
  logic [31:0] expq[$];
  bit          rxq[$];

  spi_flash_model #(
    .CS_NUM(2), .CS_IDX(0), .ADDR_BITS(24), .DUMMY_CYCLES(DUMMY), .JEDEC_ID(JID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .mosi(mosi), .miso(miso),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .err(err), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] memw(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 32'hA5C3_0F96, ~a};
  endfunction

  // Synchronous read port with one-cycle latency; every request is logged.
  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= memw(mem_addr);
      fetchq.push_back(mem_addr);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int hdr(input logic [7:0] op);
    if (op == 8'h03) return 32;
    if (op == 8'h0B) return 32 + DUMMY;
    return 8;
  endfunction

  function automatic logic [7:0] mbyte(input logic [23:0] b);
    logic [63:0] w;
    w = memw({8'h00, b[23:3], 3'b000});
    return w[int'(b[2:0]) * 8 +: 8];
  endfunction

  // Expected miso after i clocks of a transaction, from the byte-stream definition.
  function automatic logic exp_miso(input logic [7:0] op, input logic [23:0] addr, input int i);
    int          h;
    int          j;
    logic [7:0]  v;
    logic [23:0] jid;
    h   = hdr(op);
    jid = JID;
    if (i < h) return 1'b0;
    j = i - h;
    if (op == 8'h03 || op == 8'h0B) begin
      v = mbyte(addr + 24'(j / 8));
      return v[7 - (j % 8)];
    end
    if (op == 8'h9F) return jid[23 - (j % 24)];
    return 1'b0;
  endfunction

  task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int nclk, input bit keep);
    logic [31:0] frame;
    int          nsend;
    frame = {op, addr};
    nsend = (op == 8'h03 || op == 8'h0B) ? 32 : 8;
    @(negedge clk);
    cs[0] = 1'b0;
    rxq.delete();
    fetchq.delete();
    for (int i = 0; i < nclk; i++) begin
      rxq.push_back(miso);
      mosi = (i < nsend) ? frame[31 - i] : 1'($urandom);
      @(negedge clk);
    end
    if (!keep) begin
      cs[0] = 1'b1;
      mosi  = 1'b0;
    end
  endtask

  task automatic check_stream(input string nm, input logic [7:0] op, input logic [23:0] addr);
    int nb;
    nb = 0;
    for (int i = 0; i < rxq.size(); i++)
      if (rxq[i] !== exp_miso(op, addr, i)) nb++;
    check({nm, "_stream_badbits"}, 64'(nb), 64'd0);
  endtask

  task automatic check_fetch(input string nm, input logic [7:0] op, input logic [23:0] addr,
                             input int nclk);
    logic [23:0] cur;
    int          h;
    int          p0;
    expq.delete();
    if (op == 8'h03 || op == 8'h0B) begin
      h   = hdr(op);
      cur = addr & 24'hFFFFF8;
      p0  = 8 * int'(addr[2:0]);
      if (nclk >= 30) expq.push_back({8'h00, cur});
      for (int j = 0; h + j + 1 <= nclk; j++) begin
        if ((p0 + j) % 64 == 62) begin
          cur = cur + 24'd8;
          expq.push_back({8'h00, cur});
        end
      end
    end
    check({nm, "_nfetch"}, 64'(fetchq.size()), 64'(expq.size()));
    for (int k = 0; k < expq.size() && k < fetchq.size(); k++)
      check({nm, "_faddr"}, 64'(fetchq[k]), 64'(expq[k]));
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nclk;
    int          nbytes;
    logic [47:0] bytes;
    logic        err;
    logic [7:0]  ecmd;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic [7:0]  op;
    logic [23:0] addr;
    logic [47:0] got;
    int          len;
    int          h;
    string       nm;

    mem[32'h0]        = 64'h0807060504030201;
    mem[32'h8]        = 64'h100F0E0D0C0B0A09;
    mem[32'hFFFFF8]   = 64'hBBAA << 48;

    tv[0] = '{8'h03, 24'h000005, 32 + 40,      5, 48'h060708090A,   1'b0, 8'h00};
    tv[1] = '{8'h0B, 24'h000000, 32 + 8 + 24,  3, 48'h010203,       1'b0, 8'h00};
    tv[2] = '{8'h03, 24'hFFFFFE, 32 + 24,      3, 48'hAABB01,       1'b0, 8'h00};
    tv[3] = '{8'h9F, 24'h000000, 8 + 48,       6, 48'hEF4017EF4017, 1'b0, 8'h00};
    tv[4] = '{8'h05, 24'h000000, 8 + 16,       2, 48'h0000,         1'b0, 8'h00};
    tv[5] = '{8'h02, 24'h000000, 8 + 16,       2, 48'h0000,         1'b1, 8'h02};
    tv[6] = '{8'h03, 24'h000008, 18,           0, 48'h0,            1'b1, 8'h02};
    tv[7] = '{8'h03, 24'h000008, 32 + 16,      2, 48'h090A,         1'b1, 8'h02};

    repeat (3) @(negedge clk);
    check("rst_miso", 64'(miso), 64'd0);
    check("rst_mem_ren", 64'(mem_ren), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_cmd", 64'(err_cmd), 64'd0);
    rst_n = 1'b1;

    // Random legal transactions against the byte-stream model.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h03;
        1: op = 8'h0B;
        2: op = 8'h9F;
        default: op = 8'h05;
      endcase
      addr = 24'($urandom);
      if ($urandom_range(0, 3) == 0) addr = 24'hFFFFF0 + 24'($urandom_range(0, 15));
      len   = $urandom_range(0, 160);
      cs[1] = 1'($urandom);
      nm    = $sformatf("rnd%0d_op%02h", r, op);
      xfer(op, addr, hdr(op) + len, 1'b0);
      check_stream(nm, op, addr);
      check_fetch(nm, op, addr, hdr(op) + len);
      check({nm, "_err"}, 64'(err), 64'd0);
    end
    cs[1] = 1'b1;

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      nm = $sformatf("vec%0d_op%02h", v, tv[v].op);
      xfer(tv[v].op, tv[v].addr, tv[v].nclk, 1'b0);
      h   = hdr(tv[v].op);
      got = '0;
      for (int b = 0; b < tv[v].nbytes; b++)
        for (int t = 0; t < 8; t++)
          got = {got[46:0], rxq[h + 8 * b + t]};
      check({nm, "_bytes"}, 64'(got), 64'(tv[v].bytes));
      check_stream(nm, tv[v].op, tv[v].addr);
      check_fetch(nm, tv[v].op, tv[v].addr, tv[v].nclk);
      check({nm, "_err"}, 64'(err), 64'(tv[v].err));
      check({nm, "_err_cmd"}, 64'(err_cmd), 64'(tv[v].ecmd));
    end

    // Deselect while driving a 1 from the ID stream must drop miso immediately.
    xfer(8'h9F, 24'h0, 8, 1'b1);
    check("id_first_bit", 64'(miso), 64'd1);
    cs[0] = 1'b1;
    #1;
    check("desel_miso", 64'(miso), 64'd0);
    check("desel_err_kept", 64'(err), 64'd1);

    // Reset in the middle of a read: miso and err clear without a clock edge.
    xfer(8'h03, 24'h0, 32 + 7, 1'b1);
    check("pre_rst_miso", 64'(miso), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", 64'(miso), 64'd0);
    check("rst_mid_err", 64'(err), 64'd0);
    check("rst_mid_err_cmd", 64'(err_cmd), 64'd0);
    check("rst_mid_mem_ren", 64'(mem_ren), 64'd0);
    @(negedge clk);
    cs[0] = 1'b1;
    rst_n = 1'b1;

    xfer(8'h03, 24'h00000C, 32 + 24, 1'b0);
    check_stream("post_rst", 8'h03, 24'h00000C);
    check_fetch("post_rst", 8'h03, 24'h00000C, 32 + 24);
    check("post_rst_err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
